// File: rtl/pfm_pred_queue.sv
// Prefetch prediction queue: buffers predicted line addresses, drops duplicates
// against the FIFO and a recently-issued filter, and issues lines with a minimum gap.
module pfm_pred_queue #(
  parameter int ADDR_W   = 48,
  parameter int LINE_OFF = 6,
  parameter int DEPTH    = 4,
  parameter int FILTER_N = 4,
  parameter int MIN_GAP  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        pred_addr,
  input  logic                     pred_valid,
  output logic                     pred_retry,
  output logic [ADDR_W-1:0]        pf_addr,
  output logic                     pf_valid,
  input  logic                     pf_retry,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [15:0]              drop_cnt
);

  localparam int LINE_W = ADDR_W - LINE_OFF;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int FILT_W = (FILTER_N > 1) ? $clog2(FILTER_N) : 1;
  localparam int GAP_W  = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

  logic [LINE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_q, wr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [LINE_W-1:0]   filt_line_q [FILTER_N];
  logic [FILTER_N-1:0] filt_vld_q;
  logic [FILT_W-1:0]   filt_ptr_q, filt_ptr_d;

  logic [GAP_W-1:0] gap_q, gap_d;
  logic [15:0]      drop_q, drop_d;

  logic [LINE_W-1:0] in_line, head;
  logic [PTR_W-1:0]  rel;
  logic              hit, accept, enq, drop, deq;
  logic              unused_lo;

  assign in_line   = pred_addr[ADDR_W-1:LINE_OFF];
  assign unused_lo = ^pred_addr[LINE_OFF-1:0];
  assign head      = mem_q[rd_q];

  assign pred_retry = reset || flush || (cnt_q == CNT_W'(DEPTH));
  assign pf_valid   = (cnt_q != '0) && (gap_q == '0);
  assign pf_addr    = pf_valid ? {head, {LINE_OFF{1'b0}}} : '0;
  assign occupancy  = cnt_q;
  assign drop_cnt   = drop_q;

  // Entry i is live when its distance from the read pointer is below the count;
  // the head is still live in the cycle it is popped, so it also catches duplicates.
  always_comb begin
    hit = 1'b0;
    rel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel = PTR_W'(i) - rd_q;
      if ((CNT_W'(rel) < cnt_q) && (mem_q[i] == in_line)) hit = 1'b1;
    end
    for (int j = 0; j < FILTER_N; j++) begin
      if (filt_vld_q[j] && (filt_line_q[j] == in_line)) hit = 1'b1;
    end
  end

  assign accept = pred_valid && !pred_retry;
  assign enq    = accept && !hit;
  assign drop   = accept && hit;
  assign deq    = pf_valid && !pf_retry;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({enq, deq})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    gap_d = gap_q;
    if (deq)                gap_d = GAP_W'(MIN_GAP);
    else if (gap_q != '0)   gap_d = gap_q - GAP_W'(1);

    filt_ptr_d = filt_ptr_q;
    if (deq) begin
      if (filt_ptr_q == FILT_W'(FILTER_N - 1)) filt_ptr_d = '0;
      else                                     filt_ptr_d = filt_ptr_q + FILT_W'(1);
    end

    drop_d = drop_q;
    if (drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      filt_vld_q <= '0;
      filt_ptr_q <= '0;
      drop_q     <= '0;
    end else if (flush) begin
      // A transfer in this cycle still reached L1; only the queued state is dropped.
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      filt_vld_q <= '0;
      filt_ptr_q <= '0;
    end else begin
      if (enq) wr_q <= wr_q + PTR_W'(1);
      if (deq) begin
        rd_q                   <= rd_q + PTR_W'(1);
        filt_vld_q[filt_ptr_q] <= 1'b1;
      end
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      filt_ptr_q <= filt_ptr_d;
      drop_q     <= drop_d;
    end
  end

  // Payload storage needs no reset: liveness comes from the count and filter valids.
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      if (enq) mem_q[wr_q] <= in_line;
      if (deq) filt_line_q[filt_ptr_q] <= head;
    end
  end

endmodule

// File: tb/tb_pfm_pred_queue.sv
// Scoreboard bench for pfm_pred_queue: expected issues are queued at stimulus time
// and popped by a monitor that watches each pf transfer.
module tb_pfm_pred_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [47:0] pred_addr;
  logic        pred_valid;
  logic        pred_retry;
  logic [47:0] pf_addr;
  logic        pf_valid;
  logic        pf_retry;
  logic        flush;
  logic [2:0]  occupancy;
  logic [15:0] drop_cnt;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          exp_drop = 0;
  logic [47:0] exp_q [$];
  int          issue_cyc [$];

  pfm_pred_queue #(
    .ADDR_W(48), .LINE_OFF(6), .DEPTH(4), .FILTER_N(4), .MIN_GAP(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pred_addr  (pred_addr),
    .pred_valid (pred_valid),
    .pred_retry (pred_retry),
    .pf_addr    (pf_addr),
    .pf_valid   (pf_valid),
    .pf_retry   (pf_retry),
    .flush      (flush),
    .occupancy  (occupancy),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Transfers are decided at the coming edge; inputs are settled at the negedge.
  always @(negedge clk) begin
    if (!reset && pf_valid && !pf_retry) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL issue_unexpected: got pf_addr=%h, required no issue", pf_addr);
      end else begin
        logic [47:0] e;
        e = exp_q.pop_front();
        if (pf_addr !== e) begin
          bad++;
          $display("FAIL issue_addr: got %h, required %h", pf_addr, e);
        end
      end
      issue_cyc.push_back(cyc);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [47:0] a);
    pred_valid = 1'b1;
    pred_addr  = a;
    tick();
    pred_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: %0d issues outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; pred_valid = 1'b0; pred_addr = '0; pf_retry = 1'b0; flush = 1'b0;
    repeat (3) tick();
    total++; if (pred_retry !== 1'b1) begin bad++; $display("FAIL rst_pred_retry: got %b, required 1", pred_retry); end
    total++; if (pf_valid !== 1'b0) begin bad++; $display("FAIL rst_pf_valid: got %b, required 0", pf_valid); end
    total++; if (pf_addr !== 48'h0) begin bad++; $display("FAIL rst_pf_addr: got %h, required 0", pf_addr); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL rst_occupancy: got %0d, required 0", occupancy); end
    total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL rst_drop_cnt: got %0d, required 0", drop_cnt); end
    reset = 1'b0;
    tick();
    total++; if (pred_retry !== 1'b0) begin bad++; $display("FAIL post_rst_pred_retry: got %b, required 0", pred_retry); end
  endtask

  task automatic test_order_gap();
    issue_cyc.delete();
    pred_valid = 1'b1;
    pred_addr = 48'h1000; exp_q.push_back(48'h1000);
    tick();
    total++; if (pf_valid !== 1'b1 || pf_addr !== 48'h1000) begin
      bad++; $display("FAIL first_latency: got valid=%b addr=%h, required valid=1 addr=1000", pf_valid, pf_addr);
    end
    pred_addr = 48'h1040; exp_q.push_back(48'h1040);
    tick();
    pred_addr = 48'h1080; exp_q.push_back(48'h1080);
    tick();
    pred_valid = 1'b0;
    drain(40);
    total++;
    if (issue_cyc.size() != 3) begin
      bad++; $display("FAIL gap_count: got %0d issues, required 3", issue_cyc.size());
    end else if (issue_cyc[1] - issue_cyc[0] != 3 || issue_cyc[2] - issue_cyc[1] != 3) begin
      bad++; $display("FAIL gap_spacing: got %0d,%0d cycles, required 3,3",
                      issue_cyc[1] - issue_cyc[0], issue_cyc[2] - issue_cyc[1]);
    end
  endtask

  task automatic test_dedup();
    repeat (4) tick();
    exp_q.push_back(48'h2000);
    send(48'h2000);
    send(48'h2010);
    exp_drop++;
    drain(20);
    repeat (4) tick();
    total++; if (drop_cnt !== 16'(exp_drop)) begin bad++; $display("FAIL dedup_drop_cnt: got %0d, required %0d", drop_cnt, exp_drop); end
  endtask

  task automatic test_filter();
    logic [47:0] others [4];
    others[0] = 48'h4000; others[1] = 48'h4040; others[2] = 48'h4080; others[3] = 48'h40C0;
    exp_q.push_back(48'h3000);
    send(48'h3000);
    drain(20);
    repeat (4) tick();
    send(48'h3000);
    exp_drop++;
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL filter_not_enq: got occupancy %0d, required 0", occupancy); end
    repeat (3) tick();
    total++; if (drop_cnt !== 16'(exp_drop)) begin bad++; $display("FAIL filter_drop_cnt: got %0d, required %0d", drop_cnt, exp_drop); end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(others[i]);
      send(others[i]);
    end
    drain(60);
    repeat (4) tick();
    exp_q.push_back(48'h3000);
    send(48'h3000);
    drain(20);
    total++; if (drop_cnt !== 16'(exp_drop)) begin bad++; $display("FAIL evict_drop_cnt: got %0d, required %0d", drop_cnt, exp_drop); end
  endtask

  task automatic test_full();
    repeat (4) tick();
    pf_retry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(48'h5000 + 48'(i * 64));
      send(48'h5000 + 48'(i * 64));
    end
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL full_occupancy: got %0d, required 4", occupancy); end
    total++; if (pred_retry !== 1'b1) begin bad++; $display("FAIL full_retry: got %b, required 1", pred_retry); end
    pred_valid = 1'b1; pred_addr = 48'h5100;
    repeat (2) tick();
    pred_valid = 1'b0;
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL full_hold_occupancy: got %0d, required 4", occupancy); end
    total++; if (pf_valid !== 1'b1 || pf_addr !== 48'h5000) begin
      bad++; $display("FAIL full_stable: got valid=%b addr=%h, required valid=1 addr=5000", pf_valid, pf_addr);
    end
    pf_retry = 1'b0;
    drain(40);
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL full_drained: got occupancy %0d, required 0", occupancy); end
  endtask

  task automatic test_flush();
    repeat (4) tick();
    pf_retry = 1'b1;
    send(48'h6000); send(48'h6040); send(48'h6080);
    total++; if (occupancy !== 3'd3 || pf_valid !== 1'b1) begin
      bad++; $display("FAIL preflush: got occ=%0d valid=%b, required occ=3 valid=1", occupancy, pf_valid);
    end
    flush = 1'b1; pred_valid = 1'b1; pred_addr = 48'h60C0;
    #1;
    total++; if (pred_retry !== 1'b1) begin bad++; $display("FAIL flush_retry: got %b, required 1", pred_retry); end
    tick();
    flush = 1'b0; pred_valid = 1'b0;
    total++; if (occupancy !== 3'd0 || pf_valid !== 1'b0) begin
      bad++; $display("FAIL flush_clear: got occ=%0d valid=%b, required occ=0 valid=0", occupancy, pf_valid);
    end
    pf_retry = 1'b0;
    exp_q.push_back(48'h6000);
    send(48'h6000);
    drain(20);
    // Transfer coinciding with flush: counted as issued, filter still cleared.
    repeat (4) tick();
    exp_q.push_back(48'h7000);
    send(48'h7000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (pf_valid !== 1'b0) begin bad++; $display("FAIL flush_xfer_valid: got %b, required 0", pf_valid); end
    exp_q.push_back(48'h7000);
    send(48'h7000);
    drain(20);
    total++; if (drop_cnt !== 16'(exp_drop)) begin bad++; $display("FAIL flush_drop_cnt: got %0d, required %0d", drop_cnt, exp_drop); end
  endtask

  task automatic test_saturate();
    int n;
    repeat (4) tick();
    pf_retry = 1'b1;
    send(48'h8000);
    n = 65534 - exp_drop;
    pred_valid = 1'b1; pred_addr = 48'h8000;
    repeat (n) tick();
    pred_valid = 1'b0;
    exp_drop += n;
    total++; if (drop_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_pre: got %h, required fffe", drop_cnt); end
    send(48'h8010);
    total++; if (drop_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_reach: got %h, required ffff", drop_cnt); end
    send(48'h8000);
    total++; if (drop_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold: got %h, required ffff", drop_cnt); end
    total++; if (occupancy !== 3'd1) begin bad++; $display("FAIL sat_occupancy: got %0d, required 1", occupancy); end
  endtask

  task automatic test_reset_mid();
    total++; if (pf_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid: got %b, required 1", pf_valid); end
    reset = 1'b1;
    tick();
    total++; if (pf_valid !== 1'b0 || occupancy !== 3'd0) begin
      bad++; $display("FAIL mid_reset: got valid=%b occ=%0d, required valid=0 occ=0", pf_valid, occupancy);
    end
    total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL mid_reset_drop: got %0d, required 0", drop_cnt); end
    reset = 1'b0; pf_retry = 1'b0;
    repeat (10) tick();
    exp_q.push_back(48'h8000);
    send(48'h8000);
    drain(20);
    total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL mid_resend_drop: got %0d, required 0", drop_cnt); end
  endtask

  initial begin
    test_reset();
    test_order_gap();
    test_dedup();
    test_filter();
    test_full();
    test_flush();
    test_saturate();
    test_reset_mid();
    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
